// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding,
// default hold limit and a hold-counter width helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MAX_HOLD = 16;

    function automatic int hold_width(input int max_hold);
        if (max_hold > 32'sd0) begin
            return ($clog2(max_hold + 32'sd1) > 32'sd0) ? $clog2(max_hold + 32'sd1) : 32'sd1;
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_chk.sv
// Property checker for ram_arbiter outputs: one-hot grant, active/select
// consistency, hold limit and a gap between every change of owner.
module ram_arbiter_chk #(
    parameter int NUM_PORTS = 6,
    parameter int SEL_WIDTH = 3,
    parameter int MAX_HOLD  = 16
) (
    input logic                 clk_i,
    input logic                 reset_ni,
    input logic [NUM_PORTS-1:0] grant,
    input logic [SEL_WIDTH-1:0] select,
    input logic                 active
);

    logic [NUM_PORTS-1:0] prev_grant_r;
    logic                 prev_active_r;
    int                   run_r, run_s;

    // Length of the current uninterrupted grant, including this cycle
    always_comb begin
        run_s = 32'sd0;
        if (active && prev_active_r && (grant == prev_grant_r)) begin
            run_s = run_r + 32'sd1;
        end else if (active) begin
            run_s = 32'sd1;
        end else begin
            run_s = 32'sd0;
        end
    end

    // History of the previous cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prev_grant_r  <= {NUM_PORTS{1'b0}};
            prev_active_r <= 1'b0;
            run_r         <= 32'sd0;
        end else begin
            prev_grant_r  <= grant;
            prev_active_r <= active;
            run_r         <= run_s;
        end
    end

    a_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni)
        $onehot0(grant)) else $error("grant is not one-hot or zero");

    a_active: assert property (@(posedge clk_i) disable iff (!reset_ni)
        active == (|grant)) else $error("active does not match grant");

    a_select: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !active || (grant == (NUM_PORTS'(1'b1) << select))) else $error("select does not encode grant");

    a_hold: assert property (@(posedge clk_i) disable iff (!reset_ni)
        (MAX_HOLD == 32'sd0) || (run_s <= MAX_HOLD)) else $error("owner exceeded hold limit");

    a_gap: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(prev_active_r && active) || (grant == prev_grant_r)) else $error("owner changed without a gap cycle");

endmodule

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// the last owner, wrapping around; the last owner itself is checked last.
module rr_pick #(
    parameter int NUM_PORTS = 6,
    parameter int SEL_WIDTH = 3
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [SEL_WIDTH-1:0] last_i,
    output logic                 valid_o,
    output logic [SEL_WIDTH-1:0] idx_o
);

    logic [SEL_WIDTH-1:0] cand_s;

    // Scan candidates in rotating priority order starting after last_i
    always_comb begin
        valid_o = 1'b0;
        idx_o   = {SEL_WIDTH{1'b0}};
        cand_s  = {SEL_WIDTH{1'b0}};
        for (int i = 32'sd0; i < NUM_PORTS; i++) begin
            cand_s = SEL_WIDTH'((int'(last_i) + i + 32'sd1) % NUM_PORTS);
            if (!valid_o && req_i[cand_s]) begin
                valid_o = 1'b1;
                idx_o   = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for a shared single-port RAM with a bounded hold time
// and a mandatory one-cycle turnaround gap between owners.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    parameter int SEL_WIDTH = (NUM_PORTS > 32'sd1) ? $clog2(NUM_PORTS) : 32'sd1,
    parameter int MAX_HOLD  = DEFAULT_MAX_HOLD
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [SEL_WIDTH-1:0] select_o,
    output logic                 active_o,
    output logic                 busy_o
);

    localparam int                   HOLD_W   = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [SEL_WIDTH-1:0] LAST_RST = SEL_WIDTH'(NUM_PORTS - 32'sd1);

    arb_state_e           state_r, state_nx_s;
    logic [NUM_PORTS-1:0] grant_r, grant_nx_s;
    logic [SEL_WIDTH-1:0] select_r, select_nx_s;
    logic [SEL_WIDTH-1:0] last_r, last_nx_s;
    logic [HOLD_W-1:0]    hold_r, hold_nx_s;
    logic                 active_r, busy_r;
    logic                 pick_valid_s;
    logic [SEL_WIDTH-1:0] pick_idx_s;
    logic                 expire_s;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_rr_pick (
        .req_i  (req_i),
        .last_i (last_r),
        .valid_o(pick_valid_s),
        .idx_o  (pick_idx_s)
    );

    // Owner releases when its request drops or its hold budget is used up
    always_comb begin
        expire_s = !req_i[select_r];
        if ((MAX_HOLD != 32'sd0) && (hold_r >= HOLD_MAX)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = expire_s;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; BUSY always passes through GAP before a new grant
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = pick_valid_s ? BUSY : IDLE;
            BUSY:    state_nx_s = expire_s ? GAP : BUSY;
            GAP:     state_nx_s = pick_valid_s ? BUSY : IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Next values of the grant datapath; select is held through GAP
    always_comb begin
        grant_nx_s  = grant_r;
        select_nx_s = select_r;
        last_nx_s   = last_r;
        hold_nx_s   = hold_r;
        case (state_r)
            IDLE, GAP: begin
                if (pick_valid_s) begin
                    grant_nx_s  = NUM_PORTS'(1'b1) << pick_idx_s;
                    select_nx_s = pick_idx_s;
                    last_nx_s   = pick_idx_s;
                    hold_nx_s   = HOLD_W'(1'b1);
                end else begin
                    grant_nx_s  = {NUM_PORTS{1'b0}};
                end
            end
            BUSY: begin
                if (expire_s) begin
                    grant_nx_s = {NUM_PORTS{1'b0}};
                end else if (hold_r != {HOLD_W{1'b1}}) begin
                    hold_nx_s  = hold_r + HOLD_W'(1'b1);
                end else begin
                    hold_nx_s  = hold_r;
                end
            end
            default: begin
                grant_nx_s = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            grant_r  <= {NUM_PORTS{1'b0}};
            select_r <= {SEL_WIDTH{1'b0}};
            last_r   <= LAST_RST;
            hold_r   <= {HOLD_W{1'b0}};
            active_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            grant_r  <= grant_nx_s;
            select_r <= select_nx_s;
            last_r   <= last_nx_s;
            hold_r   <= hold_nx_s;
            active_r <= |grant_nx_s;
            busy_r   <= (state_nx_s != IDLE);
        end
    end

    assign grant_o  = grant_r;
    assign select_o = select_r;
    assign active_o = active_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter (6 ports, hold limit 4).
module tb_ram_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [5:0] req_i;
    logic [5:0] grant_o;
    logic [2:0] select_o;
    logic       active_o;
    logic       busy_o;

    typedef struct {
        int         cyc;
        logic       act;
        logic [5:0] g;
        logic [2:0] s;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    ram_arbiter #(.NUM_PORTS(6), .SEL_WIDTH(3), .MAX_HOLD(4)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .req_i   (req_i),
        .grant_o (grant_o),
        .select_o(select_o),
        .active_o(active_o),
        .busy_o  (busy_o)
    );

    ram_arbiter_chk #(.NUM_PORTS(6), .SEL_WIDTH(3), .MAX_HOLD(4)) u_chk (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .grant   (grant_o),
        .select  (select_o),
        .active  (active_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Apply req for the next edge and queue the outputs expected after it
    task automatic drive(input logic [5:0] r, input logic ea, input logic [5:0] eg,
                         input logic [2:0] es, input logic eb);
        exp_t e;
        req_i = r;
        e.cyc = cyc + 1;
        e.act = ea;
        e.g   = eg;
        e.s   = es;
        e.b   = eb;
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare outputs against queued expectations for this cycle
    always @(negedge clk_i) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk("stale_entry", 32'(e.cyc), 32'(cyc));
            end else begin
                chk("grant",  32'(grant_o),  32'(e.g));
                chk("active", 32'(active_o), 32'(e.act));
                chk("busy",   32'(busy_o),   32'(e.b));
                if (e.act) chk("select", 32'(select_o), 32'(e.s));
                else       chk("select_held", 32'(select_o), 32'(e.s));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] g;
        reset_ni = 1'b0;
        req_i    = 6'b000000;
        #3;
        chk("rst_grant",  32'(grant_o),  32'd0);
        chk("rst_active", 32'(active_o), 32'd0);
        chk("rst_select", 32'(select_o), 32'd0);
        chk("rst_busy",   32'(busy_o),   32'd0);
        #9 reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // All requesting: owners 0..5 then 0, 4 cycles each, gap between
        for (int k = 0; k < 7; k++) begin
            g = 6'b000001 << (k % 6);
            repeat (4) drive(6'b111111, 1'b1, g, 3'(k % 6), 1'b1);
            if (k < 6) drive(6'b111111, 1'b0, 6'b000000, 3'(k % 6), 1'b1);
        end
        drive(6'b000000, 1'b0, 6'b000000, 3'd0, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd0, 1'b0);

        // Single request from 2, one-cycle latency
        drive(6'b000100, 1'b1, 6'b000100, 3'd2, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd2, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd2, 1'b0);

        // Owner 3 ignores others, drops after 2 cycles, wrap to 1
        drive(6'b001000, 1'b1, 6'b001000, 3'd3, 1'b1);
        drive(6'b001011, 1'b1, 6'b001000, 3'd3, 1'b1);
        drive(6'b000010, 1'b0, 6'b000000, 3'd3, 1'b1);
        drive(6'b000010, 1'b1, 6'b000010, 3'd1, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd1, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd1, 1'b0);

        // Sole requester 2 is re-granted after each expiry gap
        for (int r = 0; r < 2; r++) begin
            repeat (4) drive(6'b000100, 1'b1, 6'b000100, 3'd2, 1'b1);
            drive(6'b000100, 1'b0, 6'b000000, 3'd2, 1'b1);
        end
        drive(6'b000000, 1'b0, 6'b000000, 3'd2, 1'b0);

        // Asynchronous reset in the middle of a grant
        drive(6'b010000, 1'b1, 6'b010000, 3'd4, 1'b1);
        drive(6'b010000, 1'b1, 6'b010000, 3'd4, 1'b1);
        @(negedge clk_i);
        #1;
        reset_ni = 1'b0;
        #1;
        chk("midrst_grant",  32'(grant_o),  32'd0);
        chk("midrst_active", 32'(active_o), 32'd0);
        chk("midrst_busy",   32'(busy_o),   32'd0);
        chk("midrst_select", 32'(select_o), 32'd0);
        req_i = 6'b100001;
        #1 reset_ni = 1'b1;
        drive(6'b100001, 1'b1, 6'b000001, 3'd0, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd0, 1'b1);
        drive(6'b000000, 1'b0, 6'b000000, 3'd0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 6, number of requesters sharing one RAM port.
REQ-002 SHALL have parameter SEL_WIDTH, default (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1), select width matching the RAM mux select.
REQ-003 SHALL have parameter MAX_HOLD, default 16, max consecutive grant cycles per owner; 0 = unlimited.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_i, input, NUM_PORTS, per-requester access request, level-sensitive.
REQ-007 SHALL have port grant_o, output, NUM_PORTS, one-hot registered grant.
REQ-008 SHALL have port select_o, output, SEL_WIDTH, binary index of grant owner, drives RAM mux select.
REQ-009 SHALL have port active_o, output, 1, high when a grant is valid, drives RAM mux active.
REQ-010 SHALL have port busy_o, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, GAP.
REQ-012 IDLE: when any req_i bit is high at edge n, SHALL enter BUSY with grant_o/select_o/active_o valid from cycle n+1 (1-cycle latency).
REQ-013 Winner SHALL be chosen round-robin: first requesting index strictly after last owner, wrapping NUM_PORTS-1 -> 0; after reset the last owner is NUM_PORTS-1, so index 0 has priority.
REQ-014 BUSY: grant SHALL be held while owner's req_i stays high and the hold counter is below MAX_HOLD.
REQ-015 Hold counter SHALL reset to 1 on grant, increment each BUSY cycle, and saturate; width $clog2(MAX_HOLD+1), minimum 1 bit.
REQ-016 Owner dropping req_i, or counter reaching MAX_HOLD (MAX_HOLD!=0), SHALL move BUSY -> GAP at the next edge.
REQ-017 GAP SHALL last exactly one cycle with grant_o=0, active_o=0, select_o held (write turnaround); then re-arbitrate as in IDLE, or go to IDLE if no requests.
REQ-018 In GAP, arbitration SHALL exclude nothing; a sole expired requester SHALL be re-granted after the gap.
REQ-019 grant_o SHALL be one-hot or zero in every cycle; active_o SHALL equal |grant_o; select_o SHALL equal the encoded grant_o whenever active_o=1.
REQ-020 Requests arriving during BUSY SHALL NOT preempt the owner.
REQ-021 Simultaneous owner release and new requests SHALL go through GAP; no back-to-back grants without a GAP cycle.
REQ-022 req_i bits outside the owner SHALL have no effect on outputs while in BUSY.

Reset
REQ-023 On reset_ni low, SHALL immediately (asynchronously) set state=IDLE, grant_o=0, select_o=0, active_o=0, busy_o=0, hold counter=0, last owner=NUM_PORTS-1.
REQ-024 Reset asserted mid-BUSY SHALL drop active_o in the same cycle without waiting for a clock edge.
REQ-025 After reset release, the first arbitration SHALL occur on the first rising edge with reset_ni high.

Structure
REQ-026 State enum (IDLE/BUSY/GAP) SHALL live in shared package ram_arb_pkg, together with a default MAX_HOLD constant.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last owner; outputs: valid, index).
REQ-028 select_o/active_o SHALL connect directly to the RAM mux select/active inputs with no added logic.

Verification
REQ-029 Reset then req_i=6'b000100 at edge 1 -> grant_o=6'b000100, select_o=2, active_o=1 from cycle 2.
REQ-030 req_i=6'b111111 held, MAX_HOLD=4 -> owners 0,1,2,3,4,5,0 in order; each holds 4 cycles; one GAP cycle (active_o=0) between owners.
REQ-031 Owner 3 drops req_i after 2 cycles, req_i[1] high -> GAP one cycle, then grant 1 (wrap), select_o=1.
REQ-032 Sole requester 2 held, MAX_HOLD=4 -> 4 grant cycles, 1 GAP, re-grant 2; repeats indefinitely.
REQ-033 reset_ni low mid-BUSY between edges -> grant_o=0, active_o=0 immediately; after release, req_i=6'b100001 -> grant 0.
REQ-034 Random req_i for 10k cycles -> assertions: grant_o one-hot/zero, active_o==|grant_o, no owner exceeds MAX_HOLD, GAP between all grant changes.
